mc_req_arbiter: RTL

- Sits between the request sources (axi_to_mc read/write ports, imo_controller, perops_controller) and the scheduler command input.
- Merges four requesters onto one registered command channel.
- Arbitration is fixed-priority with per-source aging, so no requester starves.
- Generates the per-command read-metadata flag that the read-metadata FIFO consumes.

---
 rtl/mc_req_arbiter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/mc_req_arbiter.sv
// -----------------------------------------------------------------------------
// mc_req_arbiter
//   Merges four memory-controller request sources (AXI read, AXI write, IMO,
//   periodic ops) onto one registered command channel that feeds the
//   scheduler. Arbitration is fixed priority (POC > IMO > AXI wr > AXI rd),
//   overridden by per-source aging so that no source starves. Each loaded
//   command also carries a read-metadata flag for the read-metadata FIFO.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   axi_rden/rdaddr/rack    AXI read request, 30-bit address, accept pulse
//   axi_wren/wraddr/wack    AXI write request, 30-bit address, accept pulse
//   imo_valid/cmd/addr/ack  IMO request, command, 60-bit address, accept pulse
//   poc_valid/cmd/addr/ack  periodic-ops request, command, address, accept
//   rng_fifo_full           RNG FIFO full; POC is not eligible while set
//   out_valid/out_ready     command register handshake towards the scheduler
//   out_src/cmd/addr        winning source index, command and address
//   out_rd_flag             bit0 AXI read, bit1 RNG (POC), bit2 IMO
//   busy                    command held or any request pending
// -----------------------------------------------------------------------------
module mc_req_arbiter #(
  parameter int               CMD_W   = 8,
  parameter logic [CMD_W-1:0] CMD_RD  = 8'h01,
  parameter logic [CMD_W-1:0] CMD_WR  = 8'h02,
  parameter int               AGE_MAX = 64,
  parameter int               AGE_W   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             axi_rden,
  input  logic [29:0]      axi_rdaddr,
  output logic             axi_rack,
  input  logic             axi_wren,
  input  logic [29:0]      axi_wraddr,
  output logic             axi_wack,
  input  logic             imo_valid,
  input  logic [CMD_W-1:0] imo_cmd,
  input  logic [59:0]      imo_addr,
  output logic             imo_ack,
  input  logic             poc_valid,
  input  logic [CMD_W-1:0] poc_cmd,
  input  logic [59:0]      poc_addr,
  output logic             poc_ack,
  input  logic             rng_fifo_full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_src,
  output logic [CMD_W-1:0] out_cmd,
  output logic [59:0]      out_addr,
  output logic [5:0]       out_rd_flag,
  output logic             busy
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

  state_e                  state_q, state_d;
  logic [3:0][AGE_W-1:0]   age_q, age_d;
  logic [1:0]              src_q, src_d;
  logic [CMD_W-1:0]        cmd_q, cmd_d;
  logic [59:0]             addr_q, addr_d;
  logic [5:0]              flag_q, flag_d;

  logic [3:0]              req_s;
  logic [3:0]              old_s;
  logic                    can_load_s;
  logic                    win_valid_s;
  logic [1:0]              win_src_s;
  logic                    grant_s;
  logic [3:0]              grant_vec_s;
  logic [CMD_W-1:0]        win_cmd_s;
  logic [59:0]             win_addr_s;
  logic [5:0]              win_flag_s;

  // Eligibility, indexed by source number; POC is masked while the RNG FIFO is full.
  assign req_s      = {poc_valid & ~rng_fifo_full, imo_valid, axi_wren, axi_rden};
  assign can_load_s = (state_q == ST_EMPTY) | out_ready;

  // Sources that have waited long enough to override fixed priority.
  always_comb begin
    old_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      old_s[i] = req_s[i] & (age_q[i] >= AGE_LIM);
    end
  end

  // Winner selection: oldest-starved lowest index first, then POC > IMO > WR > RD.
  always_comb begin
    win_valid_s = 1'b1;
    win_src_s   = 2'd0;
    if (old_s[0]) begin
      win_src_s = 2'd0;
    end else if (old_s[1]) begin
      win_src_s = 2'd1;
    end else if (old_s[2]) begin
      win_src_s = 2'd2;
    end else if (old_s[3]) begin
      win_src_s = 2'd3;
    end else if (req_s[3]) begin
      win_src_s = 2'd3;
    end else if (req_s[2]) begin
      win_src_s = 2'd2;
    end else if (req_s[1]) begin
      win_src_s = 2'd1;
    end else if (req_s[0]) begin
      win_src_s = 2'd0;
    end else begin
      win_valid_s = 1'b0;
    end
  end

  // Acks are combinational so the requester sees acceptance in the load cycle;
  // they are gated by rst_n so nothing is acknowledged while in reset.
  assign grant_s     = rst_n & can_load_s & win_valid_s;
  assign grant_vec_s = grant_s ? (4'b0001 << win_src_s) : 4'b0000;
  assign axi_rack    = grant_vec_s[0];
  assign axi_wack    = grant_vec_s[1];
  assign imo_ack     = grant_vec_s[2];
  assign poc_ack     = grant_vec_s[3];

  // Payload of the current winner, including the read-metadata flag.
  always_comb begin
    win_cmd_s  = CMD_RD;
    win_addr_s = {30'd0, axi_rdaddr};
    win_flag_s = 6'b000001;
    case (win_src_s)
      2'd0: begin
        win_cmd_s  = CMD_RD;
        win_addr_s = {30'd0, axi_rdaddr};
        win_flag_s = 6'b000001;
      end
      2'd1: begin
        win_cmd_s  = CMD_WR;
        win_addr_s = {30'd0, axi_wraddr};
        win_flag_s = 6'b000000;
      end
      2'd2: begin
        win_cmd_s  = imo_cmd;
        win_addr_s = imo_addr;
        win_flag_s = 6'b000100;
      end
      2'd3: begin
        win_cmd_s  = poc_cmd;
        win_addr_s = poc_addr;
        win_flag_s = 6'b000010;
      end
      default: begin
        win_cmd_s  = CMD_RD;
        win_addr_s = {30'd0, axi_rdaddr};
        win_flag_s = 6'b000001;
      end
    endcase
  end

  // Next state and command register: a grant always (re)loads, even while FULL,
  // which gives back-to-back issue without a bubble.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    flag_d  = flag_q;
    case (state_q)
      ST_EMPTY: begin
        if (grant_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (grant_s) begin
          state_d = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (grant_s) begin
      src_d  = win_src_s;
      cmd_d  = win_cmd_s;
      addr_d = win_addr_s;
      flag_d = win_flag_s;
    end else begin
      src_d  = src_q;
    end
  end

  // Age counters: cleared when granted or not eligible, else saturating increment.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < 4; i++) begin
      if (!req_s[i] || grant_vec_s[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] < AGE_LIM) begin
        age_d[i] = age_q[i] + AGE_ONE;
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  // State, payload and age registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      age_q   <= '0;
      src_q   <= 2'd0;
      cmd_q   <= '0;
      addr_q  <= 60'd0;
      flag_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      src_q   <= src_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      flag_q  <= flag_d;
    end
  end

  assign out_valid   = (state_q == ST_FULL);
  assign out_src     = src_q;
  assign out_cmd     = cmd_q;
  assign out_addr    = addr_q;
  assign out_rd_flag = flag_q;
  assign busy        = rst_n & (out_valid | axi_rden | axi_wren | imo_valid | poc_valid);

endmodule
